uart_cmd_ctrl: RTL and testbench

Packet-level command controller sitting between the UART byte receiver and the servo/PWM channel registers. It consumes received bytes, frames them into fixed 4-byte write commands, and validates sync, channel, range and checksum. Valid commands commit to a per-channel value register bank; invalid or stalled packets are discarded with an error pulse. It is the single writer of channel set-points, so downstream PWM generators read only `ch_value`.

---
 rtl/uart_cmd_ctrl_pkg.sv | 26 ++
 rtl/uart_cmd_ctrl_gap_timer.sv | 39 +++
 rtl/uart_cmd_ctrl.sv | 156 +++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared constants and types for the UART command controller: sync byte,
// error causes, packet FSM states and the checksum rule.
package uart_cmd_ctrl_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    ERR_TIMEOUT = 2'd0,
    ERR_CHK     = 2'd1,
    ERR_ADDR    = 2'd2,
    ERR_RANGE   = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    WAIT_SYNC = 3'd0,
    GET_ADDR  = 3'd1,
    GET_DATA  = 3'd2,
    GET_CHK   = 3'd3,
    COMMIT    = 3'd4
  } state_e;

  function automatic logic [7:0] pkt_chk(input logic [7:0] addr, input logic [7:0] data);
    return addr ^ data;
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_gap_timer.sv
// Inter-byte gap counter: clears on demand, counts while enabled, saturates at
// TIMEOUT_CLKS-1 and flags expiry there.
module cmd_gap_timer #(
  parameter int TIMEOUT_CLKS = 24000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CLKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // NOTE: sequential state is updated with <= so every flop samples the
  // pre-edge value of its neighbours, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = enable && (cnt_q == LAST);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frames received bytes into 4-byte channel write commands, validates them and
// commits the data to the per-channel set-point register bank.
module uart_cmd_ctrl
  import uart_cmd_ctrl_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int MAX_VAL      = 180,
  parameter int DEFAULT_VAL  = 90,
  parameter int TIMEOUT_CLKS = 24000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [8*NUM_CH-1:0]   ch_value,
  output logic [NUM_CH-1:0]     ch_update,
  output logic                  pkt_ok,
  output logic                  pkt_err,
  output logic [1:0]            err_code,
  output logic                  busy
);

  localparam logic [7:0] MAX_V    = 8'(MAX_VAL);
  localparam logic [7:0] DEF_V    = 8'(DEFAULT_VAL);
  localparam logic [4:0] NUM_CH_W = 5'(NUM_CH);

  state_e              state_q, state_d;
  err_code_e           err_code_q, err_code_d;
  logic                rx_valid_q;
  logic [7:0]          addr_q, addr_d, data_q, data_d, chk_q, chk_d;
  logic [7:0]          ch_q [NUM_CH];
  logic [7:0]          ch_d [NUM_CH];
  logic [NUM_CH-1:0]   ch_update_q, ch_update_d;
  logic                pkt_ok_q, pkt_ok_d, pkt_err_q, pkt_err_d, busy_q, busy_d;
  logic                byte_stb, tmr_clear, tmr_enable, tmr_expire;

  assign byte_stb   = rx_valid & ~rx_valid_q;
  assign tmr_enable = state_q inside {GET_ADDR, GET_DATA, GET_CHK};

  cmd_gap_timer #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_gap_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .expire (tmr_expire)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    chk_d       = chk_q;
    ch_d        = ch_q;
    ch_update_d = '0;
    pkt_ok_d    = 1'b0;
    pkt_err_d   = 1'b0;
    err_code_d  = err_code_q;
    tmr_clear   = 1'b0;

    case (state_q)
      WAIT_SYNC: if (byte_stb && (rx_data == SYNC_BYTE)) begin
        state_d   = GET_ADDR;
        tmr_clear = 1'b1;
      end
      GET_ADDR: if (byte_stb) begin
        addr_d    = rx_data;
        state_d   = GET_DATA;
        tmr_clear = 1'b1;
      end
      GET_DATA: if (byte_stb) begin
        data_d    = rx_data;
        state_d   = GET_CHK;
        tmr_clear = 1'b1;
      end
      GET_CHK: if (byte_stb) begin
        chk_d     = rx_data;
        state_d   = COMMIT;
        tmr_clear = 1'b1;
      end
      COMMIT: begin
        state_d = WAIT_SYNC;
        if (chk_q != pkt_chk(addr_q, data_q)) begin
          pkt_err_d  = 1'b1;
          err_code_d = ERR_CHK;
        end else if ((addr_q[7:4] != 4'd0) || ({1'b0, addr_q[3:0]} >= NUM_CH_W)) begin
          pkt_err_d  = 1'b1;
          err_code_d = ERR_ADDR;
        end else if (data_q > MAX_V) begin
          pkt_err_d  = 1'b1;
          err_code_d = ERR_RANGE;
        end else begin
          pkt_ok_d = 1'b1;
          for (int k = 0; k < NUM_CH; k++) begin
            if (addr_q[3:0] == 4'(k)) begin
              ch_d[k]        = data_q;
              ch_update_d[k] = 1'b1;
            end
          end
        end
      end
      default: state_d = WAIT_SYNC;
    endcase

    // A byte on the expiry cycle takes precedence over the timeout.
    if (tmr_expire && !byte_stb) begin
      state_d    = WAIT_SYNC;
      pkt_err_d  = 1'b1;
      err_code_d = ERR_TIMEOUT;
    end
  end

  assign busy_d = (state_d != WAIT_SYNC);

  // NOTE: the channel bank is reset like any other register because it holds
  // live set-points that downstream PWM generators read from the first cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= WAIT_SYNC;
      rx_valid_q  <= 1'b1;
      addr_q      <= '0;
      data_q      <= '0;
      chk_q       <= '0;
      for (int k = 0; k < NUM_CH; k++) ch_q[k] <= DEF_V;
      ch_update_q <= '0;
      pkt_ok_q    <= 1'b0;
      pkt_err_q   <= 1'b0;
      err_code_q  <= ERR_TIMEOUT;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_valid_q  <= rx_valid;
      addr_q      <= addr_d;
      data_q      <= data_d;
      chk_q       <= chk_d;
      ch_q        <= ch_d;
      ch_update_q <= ch_update_d;
      pkt_ok_q    <= pkt_ok_d;
      pkt_err_q   <= pkt_err_d;
      err_code_q  <= err_code_d;
      busy_q      <= busy_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    assign ch_value[8*g +: 8] = ch_q[g];
  end

  assign ch_update = ch_update_q;
  assign pkt_ok    = pkt_ok_q;
  assign pkt_err   = pkt_err_q;
  assign err_code  = err_code_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed packets from the test plan
// plus randomized packet streams checked against a byte-level packet model.
module tb_uart_cmd_ctrl;

  localparam int NUM_CH      = 4;
  localparam int MAX_VAL     = 180;
  localparam int DEFAULT_VAL = 90;
  localparam int T           = 40;  // short gap limit keeps timeouts cheap to exercise

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [7:0]          rx_data = 8'h00;
  logic                rx_valid = 1'b0;
  logic [8*NUM_CH-1:0] ch_value;
  logic [NUM_CH-1:0]   ch_update;
  logic                pkt_ok, pkt_err, busy;
  logic [1:0]          err_code;

  uart_cmd_ctrl #(
    .NUM_CH(NUM_CH), .MAX_VAL(MAX_VAL), .DEFAULT_VAL(DEFAULT_VAL), .TIMEOUT_CLKS(T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .ch_value(ch_value), .ch_update(ch_update), .pkt_ok(pkt_ok),
    .pkt_err(pkt_err), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int ok;
    int err;
    int code;
    int upd;
    int val;
  } evt_t;

  evt_t obs_q[$];
  evt_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: packet-level view of the byte stream.
  int m_chv[NUM_CH];
  bit m_in_pkt;
  int m_bytes[$];
  int m_last;
  int m_last_err;

  int last_strobe;
  int last_high;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  tag, got, got, exp, exp, cyc);
  endtask

  function automatic int lane(input int k);
    return int'(ch_value[8*k +: 8]);
  endfunction

  always @(negedge clk) begin
    if (rst_n && (pkt_ok || pkt_err || (|ch_update))) begin
      evt_t e;
      e.ok   = int'(pkt_ok);
      e.err  = int'(pkt_err);
      e.code = pkt_err ? int'(err_code) : 0;
      e.upd  = int'(ch_update);
      e.val  = -1;
      for (int k = 0; k < NUM_CH; k++) if (ch_update[k]) e.val = lane(k);
      obs_q.push_back(e);
    end
  end

  task automatic model_push(input int ok, input int code, input int ch, input int val);
    evt_t e;
    e.ok   = ok;
    e.err  = ok ? 0 : 1;
    e.code = ok ? 0 : code;
    e.upd  = ok ? (1 << ch) : 0;
    e.val  = ok ? val : -1;
    if (!ok) m_last_err = code;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) m_chv[k] = DEFAULT_VAL;
    m_in_pkt   = 1'b0;
    m_bytes.delete();
    m_last_err = 0;
  endtask

  // Byte b strobed at edge n.
  task automatic model_byte(input int b, input int n);
    int a, d, c;
    if (m_in_pkt && (n - m_last > T)) begin
      model_push(0, 0, 0, 0);
      m_in_pkt = 1'b0;
    end
    if (!m_in_pkt) begin
      if (b == 8'hA5) begin
        m_in_pkt = 1'b1;
        m_bytes.delete();
        m_last = n;
      end
    end else begin
      m_bytes.push_back(b);
      m_last = n;
      if (m_bytes.size() == 3) begin
        a = m_bytes[0]; d = m_bytes[1]; c = m_bytes[2];
        m_in_pkt = 1'b0;
        if (c != (a ^ d))      model_push(0, 1, 0, 0);
        else if (a >= NUM_CH)  model_push(0, 2, 0, 0);
        else if (d > MAX_VAL)  model_push(0, 3, 0, 0);
        else begin
          m_chv[a] = d;
          model_push(1, 0, a, d);
        end
      end
    end
  endtask

  // delta: desired edge distance from the previous strobe; hold: cycles high.
  task automatic send_byte(input int b, input int delta, input int hold);
    int n;
    n = last_strobe + delta;
    if (n < last_high + 2) n = last_high + 2;
    do @(negedge clk); while (cyc < n - 1);
    rx_data  = 8'(b);
    rx_valid = 1'b1;
    n = cyc + 1;
    repeat (hold) @(negedge clk);
    rx_valid    = 1'b0;
    last_strobe = n;
    last_high   = n + hold - 1;
    model_byte(b, n);
  endtask

  task automatic send_pkt(input int a, input int d, input int c);
    send_byte(8'hA5, 3, 1);
    send_byte(a, 3, 1);
    send_byte(d, 3, 1);
    send_byte(c, 3, 1);
  endtask

  task automatic settle();
    int m;
    repeat (T + 5) @(negedge clk);
    if (m_in_pkt) begin
      model_push(0, 0, 0, 0);
      m_in_pkt = 1'b0;
    end
    check("evt_count", obs_q.size(), exp_q.size());
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      check("evt_ok",   obs_q[i].ok,   exp_q[i].ok);
      check("evt_err",  obs_q[i].err,  exp_q[i].err);
      check("evt_code", obs_q[i].code, exp_q[i].code);
      check("evt_upd",  obs_q[i].upd,  exp_q[i].upd);
      check("evt_val",  obs_q[i].val,  exp_q[i].val);
    end
    obs_q.delete();
    exp_q.delete();
    for (int k = 0; k < NUM_CH; k++) check("lane", lane(k), m_chv[k]);
    check("idle_busy", int'(busy), 0);
    check("err_hold", int'(err_code), m_last_err);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int kind, a, d, c, hold, delta, r;

    // Reset with rx_valid already high: that byte must not be accepted.
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NUM_CH; k++) check("rst_lane", lane(k), DEFAULT_VAL);
    check("rst_update", int'(ch_update), 0);
    check("rst_ok", int'(pkt_ok), 0);
    check("rst_err", int'(pkt_err), 0);
    check("rst_code", int'(err_code), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    rx_valid    = 1'b0;
    last_high   = cyc;
    last_strobe = cyc;
    send_byte(8'h02, 3, 1);
    send_byte(8'h5A, 3, 1);
    send_byte(8'h58, 3, 1);
    settle();

    // First write with explicit commit timing.
    send_byte(8'hA5, 3, 1);
    check("busy_in_pkt", int'(busy), 1);
    send_byte(8'h02, 3, 1);
    send_byte(8'h5A, 3, 1);
    send_byte(8'h58, 3, 1);
    check("e0_ok", int'(pkt_ok), 0);
    check("e0_lane2", lane(2), DEFAULT_VAL);
    @(negedge clk);
    check("e1_update", int'(ch_update), 4'b0100);
    check("e1_ok", int'(pkt_ok), 1);
    check("e1_lane2", lane(2), 8'h5A);
    check("e1_busy", int'(busy), 0);
    @(negedge clk);
    check("e2_update", int'(ch_update), 0);
    check("e2_ok", int'(pkt_ok), 0);
    settle();

    // Checksum, address and range errors, then boundary value.
    send_pkt(8'h01, 8'h10, 8'h00);
    send_pkt(8'h01, 8'h10, 8'h11);
    send_pkt(8'h07, 8'h10, 8'h17);
    send_pkt(8'h10, 8'h05, 8'h15);
    send_pkt(8'h00, 8'hB5, 8'hB5);
    send_pkt(8'h00, 8'hB4, 8'hB4);
    settle();

    // Timeout after ADDR, byte exactly on the expiry cycle, one cycle late.
    send_byte(8'hA5, 3, 1);
    send_byte(8'h03, 3, 1);
    settle();
    send_byte(8'hA5, 3, 1);
    send_byte(8'h03, T, 1);
    send_byte(8'h10, 3, 1);
    send_byte(8'h13, 3, 1);
    send_byte(8'hA5, 3, 1);
    send_byte(8'h03, T + 1, 1);
    settle();

    // Long rx_valid level, leading garbage, 0xA5 as data.
    send_byte(8'hA5, 3, 5);
    send_byte(8'h00, 3, 5);
    send_byte(8'h33, 3, 5);
    send_byte(8'h33, 3, 5);
    send_byte(8'h00, 3, 1);
    send_byte(8'hFF, 3, 1);
    send_pkt(8'h00, 8'hA5, 8'hA5);
    settle();

    // Reset in the middle of a packet.
    send_byte(8'hA5, 3, 1);
    send_byte(8'h01, 3, 1);
    send_byte(8'h10, 3, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < NUM_CH; k++) check("midrst_lane", lane(k), DEFAULT_VAL);
    check("midrst_busy", int'(busy), 0);
    check("midrst_code", int'(err_code), 0);
    send_pkt(8'h01, 8'h20, 8'h21);
    settle();

    // Randomized packet stream.
    for (int p = 0; p < 300; p++) begin
      kind = int'($urandom_range(0, 7));
      a = int'($urandom_range(0, NUM_CH - 1));
      d = int'($urandom_range(0, MAX_VAL));
      case (kind)
        3: c = (a ^ d) ^ int'($urandom_range(1, 255));
        4: begin a = int'($urandom_range(NUM_CH, 255)); c = a ^ d; end
        5: begin d = int'($urandom_range(MAX_VAL + 1, 255)); c = a ^ d; end
        6: begin
          a = int'($urandom_range(0, 255));
          d = int'($urandom_range(0, 255));
          c = ($urandom_range(0, 1) == 0) ? (a ^ d) : int'($urandom_range(0, 255));
        end
        default: c = a ^ d;
      endcase
      if (kind == 7) send_byte(int'($urandom_range(0, 255)), 3, 1);
      for (int i = 0; i < 4; i++) begin
        hold = int'($urandom_range(1, 4));
        r = int'($urandom_range(0, 15));
        if (r == 0)      delta = T + 1;
        else if (r == 1) delta = T;
        else             delta = 1 + int'($urandom_range(1, 6));
        case (i)
          0: send_byte(8'hA5, delta, hold);
          1: send_byte(a, delta, hold);
          2: send_byte(d, delta, hold);
          default: send_byte(c, delta, hold);
        endcase
      end
      if ((p % 25) == 24) settle();
    end
    settle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
